// File: rtl/apb_line_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_line_pkg                                                     |
// | Shared state encoding and width helpers for apb_line_master.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package apb_line_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic int word_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int line_off_w(input int data_w, input int line_words);
      return $clog2(line_words * data_w / 8);
   endfunction

   function automatic int beat_cnt_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int wait_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_line_master_wait_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_wait_timer                                                   |
// | Loadable wait-state up-counter; expired_o flags the TIMEOUT-th   |
// | enabled cycle so the caller can abort on that same edge.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module apb_wait_timer
   import apb_line_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = wait_cnt_w(TIMEOUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired_o = en_i && (count_q >= CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/apb_line_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_line_master                                                  |
// | Splits line/word requests into sequential APB transfers.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module apb_line_master
   import apb_line_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic                         req_line,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [LINE_WORDS*DATA_W-1:0] req_wline,
   output logic                         rsp_valid,
   output logic                         rsp_err,
   output logic [LINE_WORDS*DATA_W-1:0] rsp_rline,
   output logic                         psel,
   output logic                         penable,
   output logic                         pwrite,
   output logic [ADDR_W-1:0]            paddr,
   output logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W-1:0]            prdata,
   input  logic                         pready,
   input  logic                         pslverr
);

   localparam int LINE_W = LINE_WORDS * DATA_W;
   localparam int WOFF_W = word_off_w(DATA_W);
   localparam int LOFF_W = line_off_w(DATA_W, LINE_WORDS);
   localparam int BEAT_W = beat_cnt_w(LINE_WORDS);
   localparam int CNT_W  = wait_cnt_w(TIMEOUT);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LOFF_W) - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] WORD_MASK = ~((ADDR_W'(1) << WOFF_W) - ADDR_W'(1));

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                err_q, err_d;
   logic                write_q, write_d;
   logic                line_q, line_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LINE_W-1:0]   wline_q, wline_d;
   logic [LINE_W-1:0]   rline_q, rline_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                in_xfer;
   logic                wait_expired;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_timer (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (state_q != ACCESS),
      .en_i       ((state_q == ACCESS) && !pready),
      .load_i     (1'b0),
      .load_val_i ({CNT_W{1'b0}}),
      .expired_o  (wait_expired)
   );

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      err_d   = err_q;
      write_d = write_q;
      line_d  = line_q;
      base_d  = base_q;
      wline_d = wline_q;
      rline_d = rline_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               line_d  = req_line;
               base_d  = req_addr & (req_line ? LINE_MASK : WORD_MASK);
               wline_d = req_wline;
               beat_d  = '0;
               err_d   = 1'b0;
               rline_d = '0;
               state_d = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready) begin
               if (pslverr) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  if (!write_q) begin
                     rline_d[beat_q*DATA_W +: DATA_W] = prdata;
                  end
                  if (!line_q || (beat_q == LAST_BEAT)) begin
                     state_d = DONE;
                  end else begin
                     beat_d  = beat_q + BEAT_W'(1);
                     state_d = SETUP;
                  end
               end
            end else if (wait_expired) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // APB outputs are computed from next-state values so they leave flops directly.
      in_xfer   = (state_d == SETUP) || (state_d == ACCESS);
      psel_d    = in_xfer;
      penable_d = (state_d == ACCESS);
      pwrite_d  = in_xfer && write_d;
      paddr_d   = in_xfer ? (base_d + (ADDR_W'(beat_d) << WOFF_W)) : '0;
      pwdata_d  = (in_xfer && write_d) ? wline_d[beat_d*DATA_W +: DATA_W] : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         err_q     <= 1'b0;
         write_q   <= 1'b0;
         line_q    <= 1'b0;
         base_q    <= '0;
         wline_q   <= '0;
         rline_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         write_q   <= write_d;
         line_q    <= line_d;
         base_q    <= base_d;
         wline_q   <= wline_d;
         rline_q   <= rline_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_err   = err_q;
   assign rsp_rline = rline_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_line_master.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_apb_line_master                                               |
// | Self-checking bench: request table plus reset-abort sequence.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_apb_line_master;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int TIMEOUT    = 8;
   localparam int LINE_W     = LINE_WORDS * DATA_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic              req_line = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [LINE_W-1:0] req_wline = '0;
   logic              rsp_valid;
   logic              rsp_err;
   logic [LINE_W-1:0] rsp_rline;
   logic              psel, penable, pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata = '0;
   logic              pready = 1'b0;
   logic              pslverr = 1'b0;

   always #5 clk = ~clk;

   apb_line_master #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_line  (req_line),
      .req_addr  (req_addr),
      .req_wline (req_wline),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rline (rsp_rline),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   typedef struct {
      logic [ADDR_W-1:0] paddr;
      logic              pwrite;
      logic [DATA_W-1:0] pwdata;
   } beat_t;

   typedef struct {
      bit                wr;
      bit                ln;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wl;
      int                waits;
      int                err_beat;
      bit                hang;
      logic [LINE_W-1:0] exp_rline;
      bit                exp_err;
      int                exp_cyc;
      int                exp_xfers;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs[6];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v);
      int cyc, acc, xfers, wcnt, beat, nbeats;
      bit done;
      logic [ADDR_W-1:0] base;
      beat_t e;
      cyc = 0; acc = 0; xfers = 0; wcnt = 0; beat = 0; done = 1'b0;

      @(negedge clk);
      chk("req_ready_idle", LINE_W'(req_ready), LINE_W'(1));
      req_valid = 1'b1;
      req_write = v.wr;
      req_line  = v.ln;
      req_addr  = v.addr;
      req_wline = v.wl;
      base   = v.ln ? {v.addr[ADDR_W-1:4], 4'h0} : {v.addr[ADDR_W-1:2], 2'b00};
      nbeats = v.ln ? LINE_WORDS : 1;
      for (int k = 0; k < nbeats; k++) begin
         e.paddr  = base + ADDR_W'(4 * k);
         e.pwrite = v.wr;
         e.pwdata = v.wr ? v.wl[k*DATA_W +: DATA_W] : '0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wline = '0;

      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = '0;
         if (rsp_valid) begin
            chk("rsp_cycle", LINE_W'(cyc), LINE_W'(v.exp_cyc));
            chk("rsp_err", LINE_W'(rsp_err), LINE_W'(v.exp_err));
            chk("rsp_rline", rsp_rline, v.exp_rline);
            done = 1'b1;
         end else if (psel && !penable) begin
            if (exp_q.size() > 0) chk("setup_paddr", LINE_W'(paddr), LINE_W'(exp_q[0].paddr));
         end else if (psel && penable) begin
            acc++;
            if (v.hang || wcnt < v.waits) begin
               wcnt++;
            end else begin
               wcnt    = 0;
               pready  = 1'b1;
               prdata  = 32'((beat + 1) * 17);
               pslverr = (beat == v.err_beat);
               if (exp_q.size() == 0) begin
                  chk("sb_underflow", LINE_W'(1), LINE_W'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("paddr", LINE_W'(paddr), LINE_W'(e.paddr));
                  chk("pwrite", LINE_W'(pwrite), LINE_W'(e.pwrite));
                  chk("pwdata", LINE_W'(pwdata), LINE_W'(e.pwdata));
               end
               xfers++;
               beat++;
            end
         end
      end
      if (!done) chk("rsp_timeout", LINE_W'(0), LINE_W'(1));
      chk("xfer_count", LINE_W'(xfers), LINE_W'(v.exp_xfers));
      chk("access_cycles", LINE_W'(acc),
          LINE_W'(v.hang ? TIMEOUT : v.exp_xfers * (v.waits + 1)));
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int beat;

      vecs[0] = '{1'b0, 1'b1, 12'h10A, '0, 0, -1, 1'b0,
                  {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 9, 4};
      vecs[1] = '{1'b1, 1'b1, 12'hFF8, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 2, -1, 1'b0,
                  '0, 1'b0, 17, 4};
      vecs[2] = '{1'b0, 1'b0, 12'h0FF, '0, 0, -1, 1'b0,
                  {32'h0, 32'h0, 32'h0, 32'h11}, 1'b0, 3, 1};
      vecs[3] = '{1'b0, 1'b1, 12'h200, '0, 0, 1, 1'b0,
                  {32'h0, 32'h0, 32'h0, 32'h11}, 1'b1, 5, 2};
      vecs[4] = '{1'b0, 1'b1, 12'h300, '0, 0, -1, 1'b1,
                  '0, 1'b1, 10, 0};
      vecs[5] = '{1'b1, 1'b0, 12'h046, 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_5555AAAA, 1, -1, 1'b0,
                  '0, 1'b0, 4, 1};

      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_psel", LINE_W'(psel), LINE_W'(0));
      chk("rst_penable", LINE_W'(penable), LINE_W'(0));
      chk("rst_paddr", LINE_W'(paddr), LINE_W'(0));
      chk("rst_rsp_valid", LINE_W'(rsp_valid), LINE_W'(0));
      chk("rst_req_ready", LINE_W'(req_ready), LINE_W'(1));
      chk("rst_rline", rsp_rline, '0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) do_req(vecs[i]);

      // Abort a line read with reset during the ACCESS phase of beat 2.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_line  = 1'b1;
      req_addr  = 12'h080;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      found = 1'b0;
      beat  = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         pready = 1'b0;
         if (psel && penable) begin
            if (beat < 2) begin
               pready = 1'b1;
               prdata = 32'hCAFE0000 + 32'(beat);
               beat++;
            end else begin
               found = 1'b1;
               reset = 1'b0;
            end
         end
      end
      chk("rst_found_beat2", LINE_W'(found), LINE_W'(1));
      @(posedge clk);
      #1;
      chk("abort_psel", LINE_W'(psel), LINE_W'(0));
      chk("abort_penable", LINE_W'(penable), LINE_W'(0));
      chk("abort_req_ready", LINE_W'(req_ready), LINE_W'(1));
      chk("abort_rsp_valid", LINE_W'(rsp_valid), LINE_W'(0));
      chk("abort_rline", rsp_rline, '0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_abort_no_rsp", LINE_W'(rsp_valid), LINE_W'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_line_master.md
# apb_line_master

Parametrised APB master between the cache controller and the APB memory slave. It accepts one request per handshake, either a full cache line or a single word, and splits it into sequential APB transfers. For reads it assembles the returned data into a line buffer. Each request ends with a one-cycle response that carries an error flag covering PSLVERR and a wait-state timeout.

## Interface
Parameters:
- ADDR_W, 12, APB/request address width (byte address)
- DATA_W, 32, APB data width; must be 32 or 64
- LINE_WORDS, 16, DATA_W-wide words per cache line; must be a power of two ≥2
- TIMEOUT, 255, maximum consecutive ACCESS cycles with pready low before abort; ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_write  in  1  1 = write, 0 = read
- req_line  in  1  1 = full line, 0 = single word
- req_addr  in  ADDR_W  byte address
- req_wline  in  LINE_WORDS*DATA_W  write data; word i in bits [i*DATA_W +: DATA_W]; single-word writes use word 0
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  PSLVERR or timeout occurred
- rsp_rline  out  LINE_WORDS*DATA_W  read data; single-word reads land in word 0
- psel, penable, pwrite  out  1 each  APB controls
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  slave ready
- pslverr  in  1  slave error, sampled with pready

## Operation
- Request capture:
  - A request is accepted on a clock edge with req_valid && req_ready.
  - On acceptance, req_write, req_line, the address and req_wline are registered.
  - Inputs are ignored at all other times.
- Address generation:
  - Line mode: base = req_addr with its low log2(LINE_WORDS*DATA_W/8) bits cleared. Beat count N = LINE_WORDS.
  - Word mode: base = req_addr with its low log2(DATA_W/8) bits cleared. N = 1.
  - Beat k drives paddr = base + k*(DATA_W/8), computed modulo 2^ADDR_W (wraps, no carry out).
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: req_ready = 1. On acceptance go to SETUP, clear the beat counter, clear err, clear rsp_rline.
  - SETUP: psel = 1, penable = 0, paddr/pwrite/pwdata valid for the current beat. Always go to ACCESS.
  - ACCESS: psel = 1, penable = 1. The wait counter increments each cycle pready is low.
    - pready = 1 and pslverr = 1: set err and go to DONE. Remaining beats are abandoned.
    - pready = 1 and pslverr = 0: on a read, store prdata into word[beat]. If this was the last beat (beat = N−1) go to DONE; otherwise increment beat and go to SETUP.
    - pready = 0 and the wait count reaches TIMEOUT: set err and go to DONE. psel drops, no data is stored.
  - DONE: rsp_valid = 1 for one cycle, then go to IDLE. req_ready = 0 in DONE.
- Outputs outside SETUP/ACCESS: psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0.
- rsp_rline and rsp_err hold their values from DONE until the next acceptance.
- On a failed read, words not yet transferred read as 0.
- Writes leave rsp_rline at 0.

## Timing
- Reset: when reset is low at a clock edge, the block enters IDLE and clears all registers. After that edge:
  - psel = penable = pwrite = 0, paddr = 0, pwdata = 0
  - rsp_valid = rsp_err = 0, rsp_rline = 0
  - req_ready = 1
- Reset mid-transfer aborts the transfer at that edge. No rsp_valid is produced and APB signals drop immediately.
- APB outputs are registered: they change only on clk edges and have no combinational path from pready.
- Zero-wait latency:
  - Acceptance at edge 0, SETUP in cycle 1, ACCESS in cycle 2.
  - Each beat takes 2 cycles.
  - rsp_valid is high in cycle 2N+1.
  - The next acceptance is possible at the end of cycle 2N+2.
- Each wait state adds 1 cycle. A timeout beat lasts TIMEOUT ACCESS cycles.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS, per APB.

## Structure
- Package apb_line_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE)
  - the localparam functions for byte-offset widths
  - beat-counter and wait-counter width helpers ($clog2 of LINE_WORDS and TIMEOUT+1)
- Sub-module apb_wait_timer: a loadable up-counter with clear, enable and an expired flag at TIMEOUT. It is instantiated once.

## Test plan
Bench configuration: ADDR_W = 12, DATA_W = 32, LINE_WORDS = 4, TIMEOUT = 8.
- Line read at req_addr 0x10A, zero-wait slave returning 0x11, 0x22, 0x33, 0x44:
  - paddr sequence is 0x100, 0x104, 0x108, 0x10C
  - rsp_valid appears in cycle 9 with rsp_rline = {0x44, 0x33, 0x22, 0x11} and rsp_err = 0
- Line write at 0xFF8 with 2 wait states per beat:
  - paddr = 0xFF0, 0xFF4, 0xFF8, 0xFFC
  - pwdata equals words 0–3 in order, rsp_valid appears in cycle 17
- Word read at 0x0FF gives paddr = 0x0FC, a single beat, and rsp_rline word0 = prdata with words 1–3 = 0.
- pslverr on beat 1 of a line read:
  - exactly 2 APB transfers occur
  - rsp_err = 1, word0 holds its data, words 1–3 = 0
- pready held low: psel drops after 8 ACCESS cycles, then rsp_valid = 1 with rsp_err = 1. A following request completes normally.
- reset driven low during ACCESS of beat 2: the next edge gives psel = 0, req_ready = 1 and no rsp_valid.
